// File: rtl/pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor
//   Qualifies the VGA PLL lock flag inside the PLL output clock domain and
//   derives from it a clean video-pipeline reset, a pixel clock-enable and a
//   debug counter of lock-loss events.
//
// Ports
//   clock           PLL output clock; every flop uses its rising edge
//   reset           asynchronous, active-high global reset
//   locked          raw PLL lock flag, asynchronous to clock
//   clear_count     synchronous clear of lock_lost_count (wins over increment)
//   rst_out         active-high downstream reset, high in every cycle that
//                   state != RUN; asserts asynchronously, releases on a clock edge
//   pix_ce          one-cycle pixel enable every PIX_DIV cycles while in RUN
//   lock_lost_count saturating count of RUN->LOST transitions
//   state           FSM state: 0 WAIT_LOCK, 1 SETTLE, 2 RUN, 3 LOST
// -----------------------------------------------------------------------------
module pll_lock_supervisor #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1024,
    parameter int PIX_DIV       = 10,
    parameter int CNT_W         = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             locked,
    input  logic             clear_count,
    output logic             rst_out,
    output logic             pix_ce,
    output logic [CNT_W-1:0] lock_lost_count,
    output logic [1:0]       state
);

    localparam int SETTLE_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int DIV_W    = $clog2(PIX_DIV);

    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(STABLE_CYCLES - 1);
    localparam logic [DIV_W-1:0]    DIV_LAST    = DIV_W'(PIX_DIV - 1);
    localparam logic [CNT_W-1:0]    CNT_MAX     = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2,
        LOST      = 2'd3
    } state_t;

    // Saturating increment: holds at all-ones instead of wrapping to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        if (value == CNT_MAX) begin
            sat_inc = value;
        end else begin
            sat_inc = value + CNT_W'(1);
        end
    endfunction

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   locked_s;
    state_t                 state_r;
    state_t                 next_state_s;
    logic [SETTLE_W-1:0]    settle_r;
    logic [SETTLE_W-1:0]    settle_next_s;
    logic [DIV_W-1:0]       div_r;
    logic [DIV_W-1:0]       div_next_s;
    logic [CNT_W-1:0]       count_r;
    logic [CNT_W-1:0]       count_next_s;
    logic                   pix_next_s;
    logic                   rst_out_r;
    logic                   pix_ce_r;

    // The last synchronizer stage is the only view of the PLL lock flag.
    assign locked_s = sync_r[SYNC_STAGES-1];

    // Lock flag synchronizer shift chain.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], locked};
        end
    end

    // Next-state and settle-counter logic.
    always_comb begin
        next_state_s  = state_r;
        settle_next_s = settle_r;
        case (state_r)
            WAIT_LOCK: begin
                if (locked_s) begin
                    next_state_s  = SETTLE;
                    settle_next_s = '0;
                end else begin
                    next_state_s = WAIT_LOCK;
                end
            end
            SETTLE: begin
                if (!locked_s) begin
                    next_state_s = WAIT_LOCK;
                end else if (settle_r == SETTLE_LAST) begin
                    next_state_s = RUN;
                end else begin
                    settle_next_s = settle_r + SETTLE_W'(1);
                end
            end
            RUN: begin
                if (!locked_s) begin
                    next_state_s = LOST;
                end else begin
                    next_state_s = RUN;
                end
            end
            LOST: begin
                next_state_s = WAIT_LOCK;
            end
            default: begin
                next_state_s = WAIT_LOCK;
            end
        endcase
    end

    // Pixel divider: free-running modulo PIX_DIV while in RUN, parked at zero
    // otherwise. The enable is suppressed on the edge that leaves RUN so that
    // it can never coincide with a high rst_out.
    always_comb begin
        div_next_s = '0;
        pix_next_s = 1'b0;
        if (state_r == RUN) begin
            if (div_r == DIV_LAST) begin
                div_next_s = '0;
            end else begin
                div_next_s = div_r + DIV_W'(1);
            end
            pix_next_s = (div_r == DIV_LAST) && (next_state_s == RUN);
        end else begin
            div_next_s = '0;
            pix_next_s = 1'b0;
        end
    end

    // Lock-loss counter; a clear in the same cycle beats the increment.
    always_comb begin
        count_next_s = count_r;
        if (clear_count) begin
            count_next_s = '0;
        end else if ((state_r == RUN) && (next_state_s == LOST)) begin
            count_next_s = sat_inc(count_r);
        end else begin
            count_next_s = count_r;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r   <= WAIT_LOCK;
            settle_r  <= '0;
            div_r     <= '0;
            count_r   <= '0;
            rst_out_r <= 1'b1;
            pix_ce_r  <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            settle_r  <= settle_next_s;
            div_r     <= div_next_s;
            count_r   <= count_next_s;
            rst_out_r <= (next_state_s != RUN);
            pix_ce_r  <= pix_next_s;
        end
    end

    assign rst_out         = rst_out_r;
    assign pix_ce          = pix_ce_r;
    assign lock_lost_count = count_r;
    assign state           = state_r;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_supervisor
//   Self-checking bench for pll_lock_supervisor (SYNC_STAGES=2,
//   STABLE_CYCLES=4, PIX_DIV=10, CNT_W=2). A cycle-level reference model is
//   advanced on every rising edge and compared with all DUT outputs; directed
//   scenarios add literal expectations for latencies and counter values.
// -----------------------------------------------------------------------------
module tb_pll_lock_supervisor;

    localparam int SYNC   = 2;
    localparam int STABLE = 4;
    localparam int PIXD   = 10;
    localparam int CW     = 2;
    localparam int CMAX   = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          locked;
    logic          clear_count;
    logic          rst_out;
    logic          pix_ce;
    logic [CW-1:0] lock_lost_count;
    logic [1:0]    state;

    pll_lock_supervisor #(
        .SYNC_STAGES  (SYNC),
        .STABLE_CYCLES(STABLE),
        .PIX_DIV      (PIXD),
        .CNT_W        (CW)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .locked         (locked),
        .clear_count    (clear_count),
        .rst_out        (rst_out),
        .pix_ce         (pix_ce),
        .lock_lost_count(lock_lost_count),
        .state          (state)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;
    int edge_no     = 0;

    // Reference model: lock history, phase number, settle count, lost count,
    // cycles spent in the current RUN interval.
    int m_hist[SYNC];
    int m_phase;
    int m_settle;
    int m_cnt;
    int m_age;
    int m_pix;
    int m_rst;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t edge=%0d)", name, act, exp, $time, edge_no);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < SYNC; i++) m_hist[i] = 0;
        m_phase  = 0;
        m_settle = 0;
        m_cnt    = 0;
        m_age    = 0;
        m_pix    = 0;
        m_rst    = 1;
        edge_no  = 0;
    endtask

    // One rising edge of the specified behaviour.
    task automatic model_edge(input int lk, input int clr);
        int ls;
        int prev;
        ls   = m_hist[SYNC-1];
        prev = m_phase;
        for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = lk;
        if (prev == 0) begin
            if (ls != 0) begin m_phase = 1; m_settle = 0; end
        end else if (prev == 1) begin
            if (ls == 0) m_phase = 0;
            else if (m_settle == STABLE - 1) m_phase = 2;
            else m_settle = m_settle + 1;
        end else if (prev == 2) begin
            if (ls == 0) m_phase = 3;
        end else begin
            m_phase = 0;
        end
        if (clr != 0) m_cnt = 0;
        else if (prev == 2 && m_phase == 3) m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
        m_age = (m_phase == 2 && prev == 2) ? m_age + 1 : 0;
        m_pix = (m_phase == 2 && m_age > 0 && (m_age % PIXD) == 0) ? 1 : 0;
        m_rst = (m_phase != 2) ? 1 : 0;
        edge_no++;
    endtask

    task automatic compare_all();
        check("state", int'(state), m_phase);
        check("rst_out", int'(rst_out), m_rst);
        check("pix_ce", int'(pix_ce), m_pix);
        check("lock_lost_count", int'(lock_lost_count), m_cnt);
    endtask

    // Called at a falling edge; drives inputs, advances one cycle, compares,
    // and returns at the next falling edge.
    task automatic step(input int lk, input int clr);
        locked      = lk[0];
        clear_count = clr[0];
        @(posedge clock);
        model_edge(lk, clr);
        #1;
        compare_all();
        @(negedge clock);
    endtask

    // Hold locked high until the DUT reports RUN; returns edges taken.
    task automatic lock_until_run(output int edges);
        int e0;
        e0    = edge_no;
        edges = 40;
        for (int i = 0; i < 40; i++) begin
            step(1, 0);
            if (state == 2'd2) begin
                edges = edge_no - e0;
                break;
            end
        end
    endtask

    // Drop locked for six cycles; returns edges until rst_out first seen high.
    task automatic drop_run(input int clr_on_third, output int rise);
        int e0;
        e0   = edge_no;
        rise = -1;
        for (int i = 0; i < 6; i++) begin
            step(0, (i == 2) ? clr_on_third : 0);
            if (rst_out && rise < 0) rise = edge_no - e0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int run_e;
        int np;
        int pe[2];
        int n;
        int saw_run;
        int exp_seq[5];
        int lk;

        exp_seq[0] = 1; exp_seq[1] = 2; exp_seq[2] = 3; exp_seq[3] = 3; exp_seq[4] = 3;

        reset       = 1'b1;
        locked      = 1'b0;
        clear_count = 1'b0;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        check("reset_state", int'(state), 0);
        check("reset_rst_out", int'(rst_out), 1);
        check("reset_pix_ce", int'(pix_ce), 0);
        check("reset_count", int'(lock_lost_count), 0);
        reset = 1'b0;

        // 1: lock from reset release, RUN at edge 7, pix_ce at 17 and 27.
        run_e = 0; np = 0; pe[0] = 0; pe[1] = 0;
        for (int i = 0; i < 40; i++) begin
            step(1, 0);
            if (state == 2'd2 && run_e == 0) run_e = edge_no;
            if (pix_ce && np < 2) begin pe[np] = edge_no; np++; end
        end
        check("run_edge", run_e, 7);
        check("first_pix_edge", pe[0], 17);
        check("second_pix_edge", pe[1], 27);
        check("count_after_lock", int'(lock_lost_count), 0);

        // 3: lock drop in RUN, then re-lock.
        drop_run(0, n);
        check("drop_to_rst_edges", n, 3);
        check("count_after_drop", int'(lock_lost_count), 1);
        lock_until_run(n);
        check("relock_edges", n, 7);
        drop_run(0, n);
        check("count_after_second_drop", int'(lock_lost_count), 2);

        // 2: short lock during SETTLE must abort back to WAIT_LOCK.
        saw_run = 0;
        for (int i = 0; i < 9; i++) begin
            step((i < 3) ? 1 : 0, 0);
            if (state == 2'd2 || !rst_out || pix_ce) saw_run = 1;
        end
        check("settle_abort_run_seen", saw_run, 0);
        check("settle_abort_state", int'(state), 0);
        check("settle_abort_count", int'(lock_lost_count), 2);

        // 4: saturating counter with CNT_W = 2.
        step(0, 1);
        check("cleared_count", int'(lock_lost_count), 0);
        for (int k = 0; k < 5; k++) begin
            lock_until_run(n);
            check("sat_relock_edges", n, 7);
            drop_run(0, n);
            check("sat_count", int'(lock_lost_count), exp_seq[k]);
        end

        // 5: clear coinciding with RUN->LOST wins.
        lock_until_run(n);
        step(0, 0);
        step(0, 0);
        step(0, 1);
        check("clear_vs_inc_state", int'(state), 3);
        check("clear_vs_inc_count", int'(lock_lost_count), 0);
        for (int i = 0; i < 4; i++) step(0, 0);

        // Randomized lock behaviour with occasional clears.
        lk = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) lk = 1 - lk;
            step(lk, ($urandom_range(0, 31) == 0) ? 1 : 0);
        end

        // 6: asynchronous reset between edges in RUN.
        lock_until_run(n);
        for (int i = 0; i < 5; i++) step(1, 0);
        #2;
        reset = 1'b1;
        #1;
        check("async_state", int'(state), 0);
        check("async_rst_out", int'(rst_out), 1);
        check("async_pix_ce", int'(pix_ce), 0);
        check("async_count", int'(lock_lost_count), 0);
        model_reset();
        @(posedge clock);
        #1;
        compare_all();
        @(negedge clock);
        reset = 1'b0;
        lock_until_run(n);
        check("post_reset_run_edges", n, 7);
        for (int i = 0; i < 25; i++) step(1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
Sits directly downstream of the VGA PLL (252 MHz out, 16 MHz ref). It consumes the PLL's asynchronous lock flag in the PLL output clock domain and synchronizes and qualifies it. It generates a clean reset for the video pipeline: asserted asynchronously, deasserted synchronously. It also generates the pixel clock-enable (252/10 = 25.2 MHz) and counts loss-of-lock events for debug.

Parameters:
SYNC_STAGES, 2, flops in the lock synchronizer; minimum 2.
STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required before reset release; minimum 1.
PIX_DIV, 10, pixel enable period in clock cycles; minimum 2.
CNT_W, 8, width of the lock-loss counter.

Ports:
clock  in  1  PLL output clock; all logic is on the rising edge.
reset  in  1  asynchronous, active-high global reset.
locked  in  1  raw PLL lock flag, asynchronous to clock.
clear_count  in  1  synchronous clear of lock_lost_count.
rst_out  out  1  active-high reset for downstream logic; deassertion is synchronous to clock.
pix_ce  out  1  one-cycle pixel enable, active only in RUN.
lock_lost_count  out  CNT_W  saturating count of RUN->LOST transitions.
state  out  2  current FSM state: 0 WAIT_LOCK, 1 SETTLE, 2 RUN, 3 LOST.

Behaviour:
- Reset (asynchronous, active-high):
  - All synchronizer flops = 0, state = WAIT_LOCK, rst_out = 1, pix_ce = 0.
  - Settle counter, divider counter and lock_lost_count = 0.
- Synchronizer: locked passes through SYNC_STAGES flops to give locked_s. No other logic samples raw locked.
- Lock pulses shorter than one clock period may be missed; this is acceptable.
- rst_out is registered and equals (next_state != RUN). It is therefore low in exactly those cycles where state == RUN.
- FSM transitions:
  - WAIT_LOCK: if locked_s = 1, go to SETTLE and set the settle counter to 0.
  - SETTLE:
    - If locked_s = 0, go to WAIT_LOCK. No count increment.
    - Else if settle counter == STABLE_CYCLES-1, go to RUN.
    - Else increment the settle counter.
  - RUN:
    - If locked_s = 0, go to LOST and increment lock_lost_count. The count saturates at 2^CNT_W-1 with no wrap.
  - LOST: unconditionally go to WAIT_LOCK after 1 cycle. rst_out = 1 and pix_ce = 0 throughout.
- Latency: with locked held high from time 0 after reset release, state becomes RUN and rst_out falls at rising edge SYNC_STAGES+1+STABLE_CYCLES.
- Lock drop: locked falling while in RUN asserts rst_out at edge SYNC_STAGES+1 after the drop.
- Pixel divider:
  - The divider counter is cleared to 0 whenever state != RUN.
  - In RUN it counts 0..PIX_DIV-1 and wraps.
  - pix_ce is a registered output, high exactly when the counter == PIX_DIV-1.
  - The first pix_ce occurs PIX_DIV cycles after entering RUN; pulses are then strictly periodic.
  - pix_ce is never high while rst_out is high.
- clear_count: sets lock_lost_count to 0 on the next edge. Clear takes priority over a simultaneous increment.
- The counter width is CNT_W. Any settle-counter width sufficient to hold STABLE_CYCLES-1 is allowed.
- Reset mid-operation (any state) returns everything to reset values immediately, without waiting for a clock edge.

Test Plan:
1. Test parameters SYNC_STAGES = 2, STABLE_CYCLES = 4, PIX_DIV = 10. Release reset and hold locked = 1 -> state passes 0, 1, 2; rst_out falls at edge 7; the first pix_ce comes 10 cycles later and then every 10 cycles; lock_lost_count = 0.
2. Toggle locked high for 3 synchronized cycles, then low, during SETTLE -> state returns to WAIT_LOCK; rst_out stays 1; lock_lost_count stays 0; no pix_ce pulse.
3. Drop locked while in RUN -> rst_out = 1 at drop+3 edges; state goes 3 then 0; lock_lost_count = 1; pix_ce = 0 from the cycle rst_out rises. Re-lock -> RUN again after 7 edges.
4. Use CNT_W = 2 and force 5 RUN->LOST cycles -> lock_lost_count reads 1, 2, 3, 3, 3.
5. Assert clear_count in the same cycle as a RUN->LOST transition -> lock_lost_count = 0 on the next edge.
6. Assert reset asynchronously mid-RUN, between clock edges -> rst_out = 1, pix_ce = 0 and state = 0 immediately. After release, the full 7-edge lock sequence repeats.
